// File: rtl/posit_encoder_if.sv
// Stream bundle for the posit encoder: decoded fields in, packed posit out.
interface posit_encoder_if #(
   parameter int N  = 32,
   parameter int SW = 9,
   parameter int FW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [SW-1:0] in_scale;
   logic [FW-1:0] in_frac;
   logic          in_sticky;
   logic          in_zero;
   logic          in_nar;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_posit;

   modport slave (
      input  in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar, out_ready,
      output in_ready, out_valid, out_posit
   );

   modport master (
      output in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar, out_ready,
      input  in_ready, out_valid, out_posit
   );
endinterface

// File: rtl/posit_encoder.sv
// Packs sign/scale/fraction/sticky/special fields into an N-bit posit with ES exponent bits.
// Capture register followed by regime-split, body-assembly and rounding stages; whole pipe stalls together.
module posit_encoder #(
   parameter int N  = 32,
   parameter int ES = 2,
   parameter int SW = 9,
   parameter int FW = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   posit_encoder_if.slave bus
);
   localparam int KW = SW - ES;
   localparam int VW = N + 1 + ES + FW;

   logic stall;
   logic advance;

   logic          v0_reg, sign0_reg, sticky0_reg, zero0_reg, nar0_reg;
   logic [SW-1:0] scale0_reg;
   logic [FW-1:0] frac0_reg;

   logic                 v1_reg, sign1_reg, sticky1_reg, zero1_reg, nar1_reg;
   logic                 sat_hi1_reg, sat_lo1_reg;
   logic signed [KW-1:0] k1_reg;
   logic [ES-1:0]        e1_reg;
   logic [FW-1:0]        frac1_reg;

   logic         v2_reg, sign2_reg, guard2_reg, sticky2_reg, zero2_reg, nar2_reg;
   logic         sat_hi2_reg, sat_lo2_reg;
   logic [N-2:0] body2_reg;

   logic         v3_reg;
   logic [N-1:0] posit3_reg;

   assign stall         = v3_reg && !bus.out_ready;
   assign advance       = !stall;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = v3_reg;
   assign bus.out_posit = posit3_reg;

   // Stage 1: regime value k is the floor of scale / 2^ES, e is the remainder.
   logic signed [KW-1:0] k_next;
   logic [ES-1:0]        e_next;
   logic                 sat_hi_next, sat_lo_next;

   always_comb begin
      k_next      = $signed(scale0_reg[SW-1:ES]);
      e_next      = scale0_reg[ES-1:0];
      sat_hi_next = int'(k_next) >= (N - 2);
      sat_lo_next = int'(k_next) < -(N - 2);
   end

   // Stage 2: an arithmetic shift of {lead, ~lead, e, frac} stretches the lead bit into the regime run.
   // For k < 0 the shift is -k-1, which is simply ~k.
   logic                 lead;
   logic [KW-1:0]        shamt;
   logic signed [VW-1:0] vec;
   logic signed [VW-1:0] shifted;
   logic [N-2:0]         body_next;
   logic                 guard_next, sticky_next;

   always_comb begin
      lead        = !k1_reg[KW-1];
      shamt       = lead ? k1_reg : ~k1_reg;
      vec         = {lead, ~lead, e1_reg, frac1_reg, {(N-1){1'b0}}};
      shifted     = vec >>> shamt;
      body_next   = shifted[VW-1 -: N-1];
      guard_next  = shifted[VW-N];
      sticky_next = (|shifted[VW-N-1:0]) | sticky1_reg;
   end

   // Stage 3: round to nearest even, clamp to [minpos, maxpos], negate, then let specials win.
   logic         round_up;
   logic [N-1:0] sum;
   logic [N-2:0] mag;
   logic [N-1:0] posit_next;

   always_comb begin
      round_up = guard2_reg && (body2_reg[0] || sticky2_reg);
      sum      = {1'b0, body2_reg} + N'(round_up);
      if (sat_hi2_reg || sum[N-1]) begin
         mag = '1;
      end else if (sat_lo2_reg || (sum[N-2:0] == '0)) begin
         mag = {{(N-2){1'b0}}, 1'b1};
      end else begin
         mag = sum[N-2:0];
      end
      posit_next = sign2_reg ? -{1'b0, mag} : {1'b0, mag};
      if (nar2_reg) begin
         posit_next = {1'b1, {(N-1){1'b0}}};
      end else if (zero2_reg) begin
         posit_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_reg     <= 1'b0;
         v1_reg     <= 1'b0;
         v2_reg     <= 1'b0;
         v3_reg     <= 1'b0;
         posit3_reg <= '0;
      end else if (advance) begin
         v0_reg <= bus.in_valid;
         v1_reg <= v0_reg;
         v2_reg <= v1_reg;
         v3_reg <= v2_reg;
         if (v2_reg) begin
            posit3_reg <= posit_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         sign0_reg   <= bus.in_sign;
         scale0_reg  <= bus.in_scale;
         frac0_reg   <= bus.in_frac;
         sticky0_reg <= bus.in_sticky;
         zero0_reg   <= bus.in_zero;
         nar0_reg    <= bus.in_nar;

         sign1_reg   <= sign0_reg;
         k1_reg      <= k_next;
         e1_reg      <= e_next;
         frac1_reg   <= frac0_reg;
         sticky1_reg <= sticky0_reg;
         zero1_reg   <= zero0_reg;
         nar1_reg    <= nar0_reg;
         sat_hi1_reg <= sat_hi_next;
         sat_lo1_reg <= sat_lo_next;

         sign2_reg   <= sign1_reg;
         body2_reg   <= body_next;
         guard2_reg  <= guard_next;
         sticky2_reg <= sticky_next;
         zero2_reg   <= zero1_reg;
         nar2_reg    <= nar1_reg;
         sat_hi2_reg <= sat_hi1_reg;
         sat_lo2_reg <= sat_lo1_reg;
      end
   end
endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined encoder that packs decoded posit fields (sign, scale, normalized fraction, sticky, special flags) into a standard N-bit posit with ES exponent bits.
- Output format matches the team's posit32_t/posit64_t layout: sign bit, then the combined regime/exponent/fraction region.
- Sits at the back end of every posit arithmetic unit. It is the inverse of the field decoder.
- Three-stage pipeline with valid/ready backpressure on both sides.

Parameters:
- N, 32, posit width (32 or 64)
- ES, 2, exponent field width
- SW, 9, width of the signed scale input (two's complement)
- FW, 32, input fraction width, hidden bit excluded; MSB weight is 2^-1

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder can accept a beat
- in_sign  in  1  sign of the value (0 positive, 1 negative)
- in_scale  in  SW  signed power-of-two scale; value = 2^scale * 1.frac
- in_frac  in  FW  fraction bits after the hidden 1
- in_sticky  in  1  OR of all bits below in_frac
- in_zero  in  1  value is exactly zero
- in_nar  in  1  value is NaR; takes priority over in_zero
- out_valid  out  1  out_posit valid
- out_ready  in  1  consumer accepts out_posit
- out_posit  out  N  encoded posit

Behaviour:
- Reset (rst_n low at a clk edge): all stage valids cleared, out_valid=0, out_posit=0, in_ready=1 on the following cycle. A reset mid-operation discards all in-flight beats with no output.
- Handshake: a beat transfers on an edge where valid && ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall. Combinational from out_ready; no dependency on in_valid.
  - While stalled, all stages hold and out_posit is stable.
  - Bubbles do not collapse; the pipe advances only as a whole.
- Latency: 3 cycles. A beat accepted at edge t appears with out_valid=1 after edge t+3 when there is no stall. Throughput is 1 beat/cycle.
- Stage 1:
  - k = in_scale >>> ES (arithmetic floor); e = in_scale[ES-1:0].
  - sat_hi = (k >= N-2); sat_lo = (k < -(N-2)).
  - Regime run length is k+1 ones followed by a 0 for k >= 0, or -k zeros followed by a 1 for k < 0.
  - Register the specials.
- Stage 2:
  - Assemble regime, e, frac into an (N-1)-bit body plus a guard bit.
  - Bits shifted past the guard are ORed with in_sticky to form sticky.
  - A truncated regime or exponent is allowed; truncated bits feed guard/sticky.
- Stage 3, rounding is round-to-nearest-even on the body:
  - round_up = guard && (lsb || sticky).
  - Result saturates: it never rounds to 0 or to NaR.
  - A body of all ones plus round_up stays maxpos = 0x7FF..F.
  - A zero body becomes minpos = 0x00..01.
  - sat_hi forces maxpos; sat_lo forces minpos.
  - If sign=1, out_posit = two's complement of {0, body}.
- Special override, applied after rounding:
  - in_nar gives out_posit = 1 followed by zeros (0x80000000 for N=32).
  - Otherwise in_zero gives all zeros.
  - in_sign and in_scale are ignored for specials.
- Simultaneous accept and output on the same edge is legal and required for full throughput.

Test Plan:
- After reset: scale=0, frac=0, sign=0 -> 0x40000000. scale=0, frac=0x80000000 -> 0x44000000. scale=4, frac=0 -> 0x60000000. sign=1, scale=0, frac=0 -> 0xC0000000. All with 3-cycle latency and back-to-back throughput.
- Rounding at scale=0 (27 fraction bits kept):
  - frac=0x00000010, sticky=0 -> 0x40000000 (tie to even).
  - frac=0x00000030 -> 0x40000002.
  - frac=0x00000010, sticky=1 -> 0x40000001.
- Saturation:
  - scale=120 -> 0x7FFFFFFF.
  - scale=200 -> 0x7FFFFFFF.
  - scale=-200 -> 0x00000001.
  - scale=-200, sign=1 -> 0xFFFFFFFF.
- Specials:
  - in_nar=1 with any fields -> 0x80000000.
  - in_zero=1, sign=1 -> 0x00000000.
  - in_nar=1 and in_zero=1 together -> 0x80000000.
- Backpressure: stream 6 beats with out_ready held low for 4 cycles mid-stream. Required:
  - in_ready drops in the same cycle as the stall.
  - out_posit is held stable.
  - No beat is lost or duplicated, and order is preserved.
- Reset with 3 beats in flight: out_valid=0 on the next cycle, no stale output afterwards, and the first post-reset beat is encoded correctly.
